// File: rtl/y86_bus_mem.sv
// y86_bus_mem: byte-addressed memory responder for the y86_seq CPU bus.
// Serves instruction fetch and data load/store with combinational reads
// and edge-committed writes, plus a byte-wide loader port for program
// preload while the CPU is held in reset. Saturating access counters and
// a sticky out-of-range error capture support checking and fault analysis.
module y86_bus_mem #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       bus_A,
    input  logic              bus_RE,
    input  logic              bus_WE,
    input  logic [31:0]       bus_out,
    output logic [31:0]       bus_in,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err,
    output logic [31:0]       err_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] idx [4];
    logic              in_range;
    logic              rd_hit;
    logic              wr_hit;
    logic              oor_hit;

    // Classify the current bus cycle: in-range read/write, or an out-of-range access.
    always_comb begin
        in_range = (bus_A[31:ADDR_W] == '0);
        rd_hit   = bus_RE & in_range & ~rst;
        wr_hit   = bus_WE & in_range & ~rst;
        oor_hit  = (bus_RE | bus_WE) & ~rst & ~in_range;
    end

    // Byte lane indices; the ADDR_W-bit add wraps a word crossing the top back to byte 0.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = bus_A[ADDR_W-1:0] + ADDR_W'(k);
        end
    end

    // Combinational little-endian read; pre-write contents when RE and WE coincide.
    always_comb begin
        bus_in = '0;
        if (rd_hit) begin
            bus_in = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
        end
    end

    // Any CPU write attempt outside reset stalls the loader, so the CPU always wins.
    assign ld_ready = ld_valid & ~(bus_WE & ~rst);

    // Memory update: CPU word write, otherwise an accepted loader byte; not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            for (int k = 0; k < 4; k++) begin
                mem[idx[k]] <= bus_out[8*k +: 8];
            end
        end else if (ld_ready) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Saturating counters of in-range reads and writes; loader traffic is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_hit && (rd_count != '1)) begin
                rd_count <= rd_count + 1'b1;
            end
            if (wr_hit && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

    // Sticky error flag; only the first out-of-range address is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (oor_hit && !err) begin
            err      <= 1'b1;
            err_addr <= bus_A;
        end
    end

endmodule
